// File: rtl/microcode_sequencer.sv
// -----------------------------------------------------------------------------
// microcode_sequencer
//
// Control unit for the 8-bit CPU. Runs a fixed two-step fetch, latches the
// opcode from the main bus at the end of the second fetch step, then walks a
// programmable microcode store indexed by {opcode, step}. The store is written
// through a simple write port, which is only honoured while the sequencer is
// halted.
//
// Handshake: prog_we is a single-cycle strobe, not a valid/ready pair. A write
// is accepted at an edge where the sequencer is in HALT, and prog_ack is high
// for exactly the following cycle. A strobe outside HALT is dropped silently
// and prog_ack stays low.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   run          level, leave HALT and begin fetching
//   halt_req     level, stop at the next instruction boundary
//   opcode_in    main bus value, sampled as FETCH_B ends
//   prog_we      microcode write strobe
//   prog_addr    write address {opcode, step}
//   prog_cw      control word to store
//   prog_last    entry is the final step of its instruction
//   prog_halt    enter HALT after this step instead of fetching
//   control_word registered control word for the current cycle
//   opcode       latched opcode
//   step         current execute step
//   halted       high while in HALT
//   prog_ack     one-cycle pulse after an accepted write
// -----------------------------------------------------------------------------
module microcode_sequencer #(
    parameter int              OP_W      = 8,
    parameter int              STEP_W    = 3,
    parameter int              CW_W      = 32,
    parameter logic [CW_W-1:0] CW_IDLE   = 32'h3BF83FCF,
    parameter logic [CW_W-1:0] FETCH_CW0 = 32'h3BF83F4F,
    parameter logic [CW_W-1:0] FETCH_CW1 = 32'h3BF82FCB
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   halt_req,
    input  logic [OP_W-1:0]        opcode_in,
    input  logic                   prog_we,
    input  logic [OP_W+STEP_W-1:0] prog_addr,
    input  logic [CW_W-1:0]        prog_cw,
    input  logic                   prog_last,
    input  logic                   prog_halt,
    output logic [CW_W-1:0]        control_word,
    output logic [OP_W-1:0]        opcode,
    output logic [STEP_W-1:0]      step,
    output logic                   halted,
    output logic                   prog_ack
);

    localparam int ADDR_W = OP_W + STEP_W;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_HALT    = 2'd0,
        S_FETCH_A = 2'd1,
        S_FETCH_B = 2'd2,
        S_EXEC    = 2'd3
    } state_t;

    state_t state;

    // Microcode store, split per field so each read port only pulls what it
    // uses. No reset: contents survive rst.
    logic [CW_W-1:0] cw_mem   [DEPTH];
    logic            last_mem [DEPTH];
    logic            halt_mem [DEPTH];

    logic [STEP_W-1:0] step_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] fetch_addr;
    logic              at_boundary;
    logic              write_ok;

    assign step_next  = step + 1'b1;
    assign cur_addr   = {opcode, step};
    assign next_addr  = {opcode, step_next};
    // First execute word is looked up straight from the bus so it can be
    // registered on the same edge that latches the opcode.
    assign fetch_addr = {opcode_in, {STEP_W{1'b0}}};

    // Instruction ends on an explicit last flag or when the step counter is
    // full; the counter is never allowed to wrap inside an instruction.
    assign at_boundary = last_mem[cur_addr] || (step == {STEP_W{1'b1}});
    assign write_ok    = prog_we && (state == S_HALT);
    assign halted      = (state == S_HALT);

    always_ff @(posedge clk) begin
        if (write_ok) begin
            cw_mem[prog_addr]   <= prog_cw;
            last_mem[prog_addr] <= prog_last;
            halt_mem[prog_addr] <= prog_halt;
        end
    end

    // Outputs are loaded with the values of the state being entered, so
    // control_word lines up with state without an extra pipeline stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_HALT;
            control_word <= CW_IDLE;
            opcode       <= '0;
            step         <= '0;
            prog_ack     <= 1'b0;
        end else begin
            prog_ack <= write_ok;
            case (state)
                S_HALT: begin
                    if (run) begin
                        state        <= S_FETCH_A;
                        control_word <= FETCH_CW0;
                    end else begin
                        control_word <= CW_IDLE;
                    end
                end
                S_FETCH_A: begin
                    state        <= S_FETCH_B;
                    control_word <= FETCH_CW1;
                end
                S_FETCH_B: begin
                    state        <= S_EXEC;
                    opcode       <= opcode_in;
                    step         <= '0;
                    control_word <= cw_mem[fetch_addr];
                end
                S_EXEC: begin
                    if (!at_boundary) begin
                        step         <= step_next;
                        control_word <= cw_mem[next_addr];
                    end else begin
                        step <= '0;
                        if (halt_mem[cur_addr] || halt_req) begin
                            state        <= S_HALT;
                            control_word <= CW_IDLE;
                        end else begin
                            state        <= S_FETCH_A;
                            control_word <= FETCH_CW0;
                        end
                    end
                end
                default: begin
                    state        <= S_HALT;
                    control_word <= CW_IDLE;
                    step         <= '0;
                end
            endcase
        end
    end

endmodule
